// File: rtl/mux4x1_rr_arbiter_pkg.sv
// rtl/mux4x1_rr_arbiter_pkg.sv - shared constants and state encoding for the 4-source mux arbiter
package mux4x1_rr_arbiter_pkg;

    localparam int N_SRC        = 4;
    localparam int IDX_W        = 2;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux4x1_rr_arbiter_pick.sv
// rtl/mux4x1_rr_arbiter_pick.sv - rotating first-set-bit finder starting at a given index
module rr_pick4
    import mux4x1_rr_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset back to start so the nearest hit is the last one written.
    always_comb begin
        idx   = start;
        found = 1'b0;
        cand  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            cand = start + IDX_W'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4x1_rr_arbiter.sv
// rtl/mux4x1_rr_arbiter.sv - round-robin owner selection driving the select of a shared 4:1 mux
module mux4x1_rr_arbiter
    import mux4x1_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CW       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] gnt,
    output logic [IDX_W-1:0] sl,
    output logic             busy
);

    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] sl_q, sl_d;
    logic             busy_q, busy_d;

    logic [N_SRC-1:0] pick_req;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             take_new;

    // gnt_q is zero in IDLE, so masking by it yields "all requests" there and "others" while granted.
    // ptr always sits one past the owner, which is exactly where both handover and preempt searches begin.
    assign pick_req = req & ~gnt_q;

    rr_pick4 u_pick (
        .req   (pick_req),
        .start (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        sl_d     = sl_q;
        busy_d   = busy_q;
        take_new = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    take_new = 1'b1;
                end
            end
            GRANT: begin
                if (!req[sl_q]) begin
                    if (pick_found) begin
                        take_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == HOLD_LIMIT && pick_found) begin
                    take_new = 1'b1;
                end else if (cnt_q != HOLD_LIMIT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (take_new) begin
            state_d = GRANT;
            gnt_d   = N_SRC'(1) << pick_idx;
            sl_d    = pick_idx;
            busy_d  = 1'b1;
            ptr_d   = pick_idx + IDX_W'(1);
            cnt_d   = CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sl_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sl_q    <= sl_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign sl   = sl_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux4x1_rr_arbiter.sv
// tb/tb_mux4x1_rr_arbiter.sv - directed vector bench for the round-robin mux arbiter
module tb_mux4x1_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sl;
    logic       busy;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sl;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    mux4x1_rr_arbiter #(.MAX_HOLD(4), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .sl    (sl),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input logic eb);
        check({name, ".gnt"}, gnt, eg);
        check({name, ".sl"}, {2'b00, sl}, {2'b00, es});
        check({name, ".busy"}, {3'b000, busy}, {3'b000, eb});
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s, input logic b);
        vec_t v;
        v.req  = r;
        v.gnt  = g;
        v.sl   = s;
        v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Full contention: four cycles per owner, rotating 0,1,2,3 then back to 0.
        for (int k = 0; k < 4; k++) add(4'b1111, 4'b0001, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) add(4'b1111, 4'b0010, 2'd1, 1'b1);
        for (int k = 0; k < 4; k++) add(4'b1111, 4'b0100, 2'd2, 1'b1);
        for (int k = 0; k < 4; k++) add(4'b1111, 4'b1000, 2'd3, 1'b1);
        add(4'b1111, 4'b0001, 2'd0, 1'b1);
        // Lone requester 2: handover without a bubble, then never preempted.
        for (int k = 0; k < 11; k++) add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        // ptr=3: search 3,0 picks owner 0; early release hands straight to 2.
        add(4'b0101, 4'b0001, 2'd0, 1'b1);
        add(4'b0101, 4'b0001, 2'd0, 1'b1);
        add(4'b0100, 4'b0100, 2'd2, 1'b1);
        // Owner 3 exhausts its hold with req=1010; wrap search from 0 lands on 1.
        add(4'b1000, 4'b1000, 2'd3, 1'b1);
        for (int k = 0; k < 3; k++) add(4'b1010, 4'b1000, 2'd3, 1'b1);
        add(4'b1010, 4'b0010, 2'd1, 1'b1);
        add(4'b0000, 4'b0000, 2'd1, 1'b0);

        rst_n = 1'b0;
        req   = 4'b1111;
        #2;
        check_out("rst_async", 4'b0000, 2'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check_out("rst_hold", 4'b0000, 2'd0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].req;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sl, vecs[i].busy);
            @(negedge clk);
        end

        // Idle with ptr=2: req 0100 grants 2, then reset mid-grant clears outputs at once.
        req = 4'b0100;
        @(posedge clk);
        #1;
        check_out("pre_rst", 4'b0100, 2'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_rst", 4'b0001, 2'd0, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_out("post_rst_hold", 4'b0001, 2'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
